// File: rtl/uart_burst_bridge_if.sv
// Signal bundle shared by the UART byte core, the register bank and the burst bridge.
// The bridge takes the master view; the surrounding environment takes the slave view.
interface uart_burst_bridge_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_BYTES = 2
);
  localparam int unsigned DATA_W = 8 * DATA_BYTES;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_error;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_write;
  logic              bus_read;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;
  logic [7:0]        err_count;

  modport master (
    input  rx_data, rx_valid, rx_error, tx_ready, bus_rdata,
    output tx_data, tx_valid, bus_addr, bus_wdata, bus_write, bus_read, busy, err_count
  );

  modport slave (
    output rx_data, rx_valid, rx_error, tx_ready, bus_rdata,
    input  tx_data, tx_valid, bus_addr, bus_wdata, bus_write, bus_read, busy, err_count
  );
endinterface

// File: rtl/uart_burst_bridge.sv
// Byte-stream command decoder: turns UART command/address/data bytes into register bus
// write and read bursts, streams read data back, and recovers from lost sync on its own.
module uart_burst_bridge #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_BYTES     = 2,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                 clk,
  input logic                 reset,
  uart_burst_bridge_if.master bif
);
  localparam int unsigned DATA_W     = 8 * DATA_BYTES;
  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StRreq,
    StRwait,
    StRsend
  } state_e;

  state_e            state_q, state_d;
  logic              read_q, read_d;
  logic              inc_q, inc_d;
  logic [5:0]        words_left_q, words_left_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_valid_q, tx_valid_d;
  logic              bus_write_q, bus_write_d;
  logic [7:0]        err_q, err_d;
  logic              err_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      inc_q        <= 1'b0;
      words_left_q <= '0;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_sh_q      <= '0;
      tx_valid_q   <= 1'b0;
      bus_write_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      inc_q        <= inc_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tx_sh_q      <= tx_sh_d;
      tx_valid_q   <= tx_valid_d;
      bus_write_q  <= bus_write_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    inc_d        = inc_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tx_sh_d      = tx_sh_q;
    tx_valid_d   = tx_valid_q;
    bus_write_d  = 1'b0;
    err_inc      = 1'b0;

    // Post-increment only once the strobe cycle has shown the old address.
    if (bus_write_q && inc_q) begin
      addr_d = addr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bif.rx_valid && !bif.rx_error) begin
          read_d       = bif.rx_data[7];
          inc_d        = bif.rx_data[6];
          words_left_d = bif.rx_data[5:0];
          byte_cnt_d   = '0;
          idle_cnt_d   = '0;
          state_d      = StAddr;
        end
      end

      StAddr: begin
        if (bif.rx_valid) begin
          addr_d     = ADDR_W'({addr_q, bif.rx_data});
          idle_cnt_d = '0;
          if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = read_q ? StRreq : StWdata;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      StWdata: begin
        if (bif.rx_valid) begin
          wdata_d    = DATA_W'({wdata_q, bif.rx_data});
          idle_cnt_d = '0;
          if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
            byte_cnt_d  = '0;
            bus_write_d = 1'b1;
            if (words_left_q == '0) begin
              state_d = StIdle;
            end else begin
              words_left_d = words_left_q - 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      StRreq: begin
        err_inc   = bif.rx_valid;
        lat_cnt_d = 4'd1;
        state_d   = StRwait;
      end

      StRwait: begin
        err_inc = bif.rx_valid;
        if (lat_cnt_q == 4'(RD_LATENCY)) begin
          tx_sh_d    = bif.bus_rdata;
          tx_valid_d = 1'b1;
          byte_cnt_d = '0;
          state_d    = StRsend;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      StRsend: begin
        err_inc = bif.rx_valid;
        if (tx_valid_q && bif.tx_ready) begin
          tx_sh_d = tx_sh_q << 8;
          if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
            tx_valid_d = 1'b0;
            byte_cnt_d = '0;
            if (words_left_q != '0) begin
              words_left_d = words_left_q - 1'b1;
              if (inc_q) begin
                addr_d = addr_q + 1'b1;
              end
              state_d = StRreq;
            end else begin
              state_d = StIdle;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A framing error drops the byte and overrides whatever it would have done.
    if (bif.rx_error) begin
      err_inc     = 1'b1;
      bus_write_d = 1'b0;
      tx_valid_d  = 1'b0;
      state_d     = StIdle;
    end

    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 1'b1;
    end
  end

  assign bif.tx_data   = tx_sh_q[DATA_W-1 -: 8];
  assign bif.tx_valid  = tx_valid_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.bus_write = bus_write_q;
  assign bif.bus_read  = (state_q == StRreq);
  assign bif.busy      = (state_q != StIdle);
  assign bif.err_count = err_q;
endmodule

// File: doc/uart_burst_bridge.md
Name: uart_burst_bridge

Overview:
Byte-stream command decoder between the UART byte core and the internal register bank. It is the parametrised successor of the single-byte UART command interface. It adds multi-byte addresses, multi-byte data words, burst transfers with optional address auto-increment, fixed-latency bus reads, and tx flow control. It also adds inter-byte timeout and error counting, so a host that loses sync recovers without a reset.

Parameters:
ADDR_W, 16, bus address width (1..32); ADDR_BYTES = ceil(ADDR_W/8)
DATA_BYTES, 2, bytes per bus word (1..4); DATA_W = 8*DATA_BYTES
RD_LATENCY, 1, cycles from bus_read pulse to valid bus_rdata (1..15)
TIMEOUT_CYCLES, 1000, max idle cycles between rx bytes inside a command (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe: rx_data valid
rx_error  input  1  one-cycle strobe: framing error on current byte
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data valid; held until tx_ready
tx_ready  input  1  UART core accepts tx_data this cycle
bus_addr  output  ADDR_W  bus address
bus_wdata  output  DATA_W  write data
bus_write  output  1  one-cycle write strobe
bus_read  output  1  one-cycle read strobe
bus_rdata  input  DATA_W  read data, valid RD_LATENCY cycles after bus_read
busy  output  1  high whenever state != IDLE
err_count  output  8  saturating count of aborted commands and dropped bytes

Behaviour:
- Clocking and reset: single clock domain. All state updates on the rising edge of clk. reset is synchronous and active-high.
- Reset values: state=IDLE, bus_addr=0, bus_wdata=0, bus_write=0, bus_read=0, tx_data=0, tx_valid=0, err_count=0, busy=0. Reset mid-operation abandons the command at the next edge; no further strobes are issued.
- Command byte: bit7=1 read, 0 write; bit6=1 auto-increment; bits5:0 = burst length minus 1 (1..64 words).
- Address: ADDR_BYTES bytes follow, MSB first. Unused upper bits of the top byte are ignored.
- States: IDLE, ADDR, WDATA, RREQ, RWAIT, RSEND.
- IDLE: on rx_valid, latch command, clear byte counter, go to ADDR.
- ADDR: shift in address bytes. After the last byte, go to WDATA (write) or RREQ (read).
- WDATA: shift in bytes MSB first into bus_wdata. The cycle after the last byte of a word, bus_write=1 for exactly one cycle with stable bus_addr/bus_wdata. After the last word, go to IDLE.
- Address update: if auto-increment is set, bus_addr increments by 1 after each word's strobe, wrapping modulo 2^ADDR_W. Otherwise it is unchanged.
- RREQ: bus_read=1 for one cycle, then go to RWAIT.
- RWAIT: count RD_LATENCY cycles, capture bus_rdata into the tx shift register, go to RSEND.
- RSEND: present bytes MSB first. tx_valid is held with a stable tx_data until tx_ready. A byte completes on the cycle where tx_valid and tx_ready are both high. After the last byte of the word:
  - if more words remain, apply the address update and go to RREQ;
  - otherwise go to IDLE.
- Timeout: in ADDR/WDATA, an idle counter resets on each rx_valid. Reaching TIMEOUT_CYCLES aborts to IDLE, err_count+1, no strobe.
- rx_error: in any state, the byte is dropped. Inside a command it aborts to IDLE with err_count+1. In IDLE it gives err_count+1 only. rx_error wins over a simultaneous rx_valid.
- rx_valid during RREQ/RWAIT/RSEND: byte dropped, err_count+1, the read burst continues.
- err_count saturates at 255.
- Latency, 1-word write: bus_write one cycle after the final data byte's rx_valid.

Test Plan:
1. Single write: rx 0x00,0x12,0x34,0xAB,0xCD → exactly one bus_write, bus_addr=0x1234, bus_wdata=0xABCD, one cycle after the 0xCD strobe; busy low after.
2. Burst write with wrap: rx 0x42,0xFF,0xFF, then 6 data bytes 0x0001,0x0002,0x0003 → writes (0xFFFF,0x0001),(0x0000,0x0002),(0x0001,0x0003).
3. Read burst, no-inc, tx stalls:
   - Stimulus: rx 0x81,0x00,0x10; bus model returns 0xBEEF RD_LATENCY after each bus_read; tx_ready low 5 cycles per byte.
   - Response: two bus_read pulses, both at addr 0x0010; tx sequence BE,EF,BE,EF; tx_data stable while stalled.
4. Timeout: rx 0x00,0x12, then silence for 1000 cycles → IDLE, err_count=1, no bus_write. A following complete write executes correctly.
5. rx_error on the 2nd data byte of a write → no bus_write, IDLE, err_count=1. A stray rx byte during a read burst → err_count=2, read completes intact.
6. Reset asserted during RSEND → the next cycle tx_valid=0, busy=0, err_count=0, and no further bus_read pulses.
